// File: rtl/gdb_rsp_tx.sv
// gdb_rsp_tx: GDB Remote Serial Protocol packet transmitter.
// Frames a raw payload stream as "$<payload>#<hh>". The bytes '#', '$', '}' and '*'
// are sent as '}' followed by the byte XOR 0x20. <hh> is the lowercase hex mod-256 sum
// of every byte sent between '$' and '#'.
// Optional feature macro: GDB_RSP_TX_RETRY_EN. It adds the retransmit buffer, the
// ack wait, the timeout and the retry logic. Without it, the block returns to IDLE
// straight after the checksum and ignores ack_*.
module gdb_rsp_tx #(
   parameter int DEPTH     = 256,
   parameter int TIMEOUT   = 1000000,
   parameter int MAX_RETRY = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_vld,
   output logic       in_rdy,
   input  logic [7:0] in_dat,
   input  logic       in_lst,
   input  logic       in_emp,
   output logic       out_vld,
   input  logic       out_rdy,
   output logic [7:0] out_dat,
   input  logic       ack_vld,
   input  logic       ack_nak,
   output logic       busy,
   output logic       err_ovf,
   output logic       err_retry
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_START    = 3'd1,
      S_DATA     = 3'd2,
      S_ESC      = 3'd3,
      S_HASH     = 3'd4,
      S_CSUM_HI  = 3'd5,
      S_CSUM_LO  = 3'd6,
      S_WAIT_ACK = 3'd7
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic [7:0] r_csum;

   logic       w_replay;
   logic       w_src_vld;
   logic [7:0] w_src_dat;
   logic       w_src_lst;
   logic       w_head_emp;
   logic       w_esc;
   logic       w_out_vld;
   logic [7:0] w_out_dat;
   logic       w_in_rdy;
   logic       w_xfer;
   logic       w_acc;
   logic       w_adv;

   // Lowercase ASCII hex digit for one nibble
   function automatic logic [7:0] f_hex(input logic [3:0] n);
      if (n < 4'd10) begin
         f_hex = 8'h30 + {4'h0, n};
      end else begin
         f_hex = 8'h57 + {4'h0, n};
      end
   endfunction

   // True for the bytes that must be sent with a '}' prefix
   function automatic logic f_needs_esc(input logic [7:0] b);
      f_needs_esc = (b == 8'h23) || (b == 8'h24) || (b == 8'h7D) || (b == 8'h2A);
   endfunction

`ifdef GDB_RSP_TX_RETRY_EN
   localparam int AW = $clog2(DEPTH);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int RW = $clog2(MAX_RETRY + 1);
   localparam logic [AW:0]   C_ONE_P = (AW+1)'(1);
   localparam logic [RW-1:0] C_ONE_R = RW'(1);

   logic [7:0]    r_buf [0:DEPTH-1];
   logic [AW:0]   r_wptr;
   logic [AW:0]   r_rptr;
   logic [AW:0]   r_len;
   logic          r_replay;
   logic          r_ovf_pkt;
   logic          r_err_ovf;
   logic          r_err_retry;
   logic [TW-1:0] r_tmr;
   logic [RW-1:0] r_retry;
   logic          w_timeout;
   logic          w_ack_ok;
   logic          w_retry_ev;
   logic [RW-1:0] w_retry_inc;
   logic          w_wr;

   assign w_replay    = r_replay;
   assign w_timeout   = (r_tmr == TW'(TIMEOUT - 1));
   assign w_ack_ok    = ack_vld && !ack_nak;
   // An ack on the same cycle as the timeout wins over the timeout
   assign w_retry_ev  = (ack_vld && ack_nak) || (!ack_vld && w_timeout);
   assign w_retry_inc = r_retry + C_ONE_R;
   // r_wptr saturates at DEPTH, so its top bit marks a full buffer
   assign w_wr        = w_acc && (r_state != S_START) && !r_wptr[AW];

   // Payload source: the live input on first transmission, the buffer on replay
   always_comb begin
      if (r_replay) begin
         w_src_vld  = 1'b1;
         w_src_dat  = r_buf[r_rptr[AW-1:0]];
         w_src_lst  = ((r_rptr + C_ONE_P) == r_len);
         w_head_emp = (r_len == '0);
      end else begin
         w_src_vld  = in_vld;
         w_src_dat  = in_dat;
         w_src_lst  = in_lst;
         w_head_emp = in_vld && in_lst && in_emp;
      end
   end

   // Retransmit buffer storage, written with raw (unescaped) payload bytes
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_buf[r_wptr[AW-1:0]] <= in_dat;
      end
   end

   // Retransmit bookkeeping: pointers, length, timer, retry count, sticky errors
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_len       <= '0;
         r_replay    <= 1'b0;
         r_ovf_pkt   <= 1'b0;
         r_err_ovf   <= 1'b0;
         r_err_retry <= 1'b0;
         r_tmr       <= '0;
         r_retry     <= '0;
      end else begin
         if (r_state == S_IDLE) begin
            r_replay  <= 1'b0;
            r_wptr    <= '0;
            r_ovf_pkt <= 1'b0;
            r_retry   <= '0;
         end
         if (r_state == S_START) begin
            r_rptr <= '0;
            if (w_acc) begin
               r_len <= '0;
            end
         end
         if (w_acc && (r_state != S_START)) begin
            if (r_wptr[AW]) begin
               r_ovf_pkt <= 1'b1;
               r_err_ovf <= 1'b1;
            end else begin
               r_wptr <= r_wptr + C_ONE_P;
               if (in_lst) begin
                  r_len <= r_wptr + C_ONE_P;
               end
            end
         end
         if (r_replay && w_adv) begin
            r_rptr <= r_rptr + C_ONE_P;
         end
         if (r_state == S_WAIT_ACK) begin
            r_tmr <= r_tmr + TW'(1);
         end else begin
            r_tmr <= '0;
         end
         if ((r_state == S_WAIT_ACK) && !w_ack_ok && w_retry_ev) begin
            if (r_ovf_pkt) begin
               r_retry <= '0;
            end else if (w_retry_inc == RW'(MAX_RETRY)) begin
               r_err_retry <= 1'b1;
               r_retry     <= '0;
            end else begin
               r_retry  <= w_retry_inc;
               r_replay <= 1'b1;
            end
         end else if ((r_state == S_WAIT_ACK) && w_ack_ok) begin
            r_retry <= '0;
         end
      end
   end

   assign err_ovf   = r_err_ovf;
   assign err_retry = r_err_retry;
`else
   logic w_unused;

   assign w_replay  = 1'b0;
   assign w_unused  = ack_vld ^ ack_nak ^ (DEPTH > 0) ^ (TIMEOUT > 0) ^ (MAX_RETRY > 0);

   // Payload source: always the live input stream
   always_comb begin
      w_src_vld  = in_vld;
      w_src_dat  = in_dat;
      w_src_lst  = in_lst;
      w_head_emp = in_vld && in_lst && in_emp;
   end

   assign err_ovf   = 1'b0;
   assign err_retry = 1'b0;
`endif

   assign w_esc  = f_needs_esc(w_src_dat);
   assign w_xfer = w_out_vld && out_rdy;
   assign w_acc  = in_vld && w_in_rdy;
   // A payload byte is consumed when its final output byte transfers
   assign w_adv  = w_xfer && (((r_state == S_DATA) && !w_esc) || (r_state == S_ESC));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (in_vld) begin
               w_next = S_START;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_START: begin
            if (w_xfer) begin
               w_next = w_head_emp ? S_HASH : S_DATA;
            end else begin
               w_next = S_START;
            end
         end
         S_DATA: begin
            if (w_xfer && w_esc) begin
               w_next = S_ESC;
            end else if (w_xfer && w_src_lst) begin
               w_next = S_HASH;
            end else begin
               w_next = S_DATA;
            end
         end
         S_ESC: begin
            if (w_xfer) begin
               w_next = w_src_lst ? S_HASH : S_DATA;
            end else begin
               w_next = S_ESC;
            end
         end
         S_HASH: begin
            if (w_xfer) begin
               w_next = S_CSUM_HI;
            end else begin
               w_next = S_HASH;
            end
         end
         S_CSUM_HI: begin
            if (w_xfer) begin
               w_next = S_CSUM_LO;
            end else begin
               w_next = S_CSUM_HI;
            end
         end
         S_CSUM_LO: begin
            if (w_xfer) begin
`ifdef GDB_RSP_TX_RETRY_EN
               w_next = S_WAIT_ACK;
`else
               w_next = S_IDLE;
`endif
            end else begin
               w_next = S_CSUM_LO;
            end
         end
         S_WAIT_ACK: begin
`ifdef GDB_RSP_TX_RETRY_EN
            if (w_ack_ok) begin
               w_next = S_IDLE;
            end else if (w_retry_ev) begin
               if (r_ovf_pkt || (w_retry_inc == RW'(MAX_RETRY))) begin
                  w_next = S_IDLE;
               end else begin
                  w_next = S_START;
               end
            end else begin
               w_next = S_WAIT_ACK;
            end
`else
            w_next = S_IDLE;
`endif
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Output logic: framing bytes, zero-latency payload pass-through, input ready
   always_comb begin
      w_out_vld = 1'b0;
      w_out_dat = 8'h00;
      w_in_rdy  = 1'b0;
      case (r_state)
         S_START: begin
            w_out_vld = 1'b1;
            w_out_dat = 8'h24;
            w_in_rdy  = !w_replay && w_head_emp && out_rdy;
         end
         S_DATA: begin
            w_out_vld = w_src_vld;
            if (w_esc) begin
               w_out_dat = 8'h7D;
            end else begin
               w_out_dat = w_src_dat;
               w_in_rdy  = !w_replay && out_rdy;
            end
         end
         S_ESC: begin
            w_out_vld = w_src_vld;
            w_out_dat = w_src_dat ^ 8'h20;
            w_in_rdy  = !w_replay && out_rdy;
         end
         S_HASH: begin
            w_out_vld = 1'b1;
            w_out_dat = 8'h23;
         end
         S_CSUM_HI: begin
            w_out_vld = 1'b1;
            w_out_dat = f_hex(r_csum[7:4]);
         end
         S_CSUM_LO: begin
            w_out_vld = 1'b1;
            w_out_dat = f_hex(r_csum[3:0]);
         end
         default: begin
            w_out_vld = 1'b0;
         end
      endcase
   end

   // Running checksum of every byte sent between '$' and '#'
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_csum <= 8'h00;
      end else if (r_state == S_START) begin
         r_csum <= 8'h00;
      end else if (((r_state == S_DATA) || (r_state == S_ESC)) && w_xfer) begin
         r_csum <= r_csum + w_out_dat;
      end
   end

   assign out_vld = w_out_vld;
   assign out_dat = w_out_dat;
   assign in_rdy  = w_in_rdy;
   assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_gdb_rsp_tx.sv
// Testbench for gdb_rsp_tx: the reference model builds each expected frame from the payload.
// A monitor checks every transferred byte and the stall stability against that model.
module tb_gdb_rsp_tx;
   localparam int P_DEPTH     = 16;
   localparam int P_TIMEOUT   = 16;
   localparam int P_MAX_RETRY = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_vld, in_rdy, in_lst, in_emp;
   logic [7:0] in_dat;
   logic       out_vld, out_rdy;
   logic [7:0] out_dat;
   logic       ack_vld, ack_nak;
   logic       busy, err_ovf, err_retry;

   int         total = 0;
   int         bad   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] cap_q[$];
   bit         mon_en = 1'b0;
   bit         bp_en  = 1'b0;
   logic       prev_stall;
   logic [7:0] prev_dat;

   always #5 clk = ~clk;

   gdb_rsp_tx #(.DEPTH(P_DEPTH), .TIMEOUT(P_TIMEOUT), .MAX_RETRY(P_MAX_RETRY)) dut (
      .clk(clk), .rst(rst),
      .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat), .in_lst(in_lst), .in_emp(in_emp),
      .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat),
      .ack_vld(ack_vld), .ack_nak(ack_nak),
      .busy(busy), .err_ovf(err_ovf), .err_retry(err_retry)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   // Reference model: append the full frame for one payload to the expected stream
   task automatic model_frame(input logic [7:0] pl[$]);
      string      hx = "0123456789abcdef";
      logic [7:0] s  = 8'h00;
      logic [7:0] b;
      exp_q.push_back(8'h24);
      foreach (pl[i]) begin
         if (pl[i] inside {8'h23, 8'h24, 8'h2A, 8'h7D}) begin
            b = pl[i] ^ 8'h20;
            exp_q.push_back(8'h7D);
            exp_q.push_back(b);
            s = s + 8'h7D + b;
         end else begin
            exp_q.push_back(pl[i]);
            s = s + pl[i];
         end
      end
      exp_q.push_back(8'h23);
      exp_q.push_back(hx[s[7:4]]);
      exp_q.push_back(hx[s[3:0]]);
   endtask

   // Sink ready: always 1, or random when backpressure is enabled
   initial begin
      out_rdy = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_rdy = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   // Monitor: every transferred byte must match the model; stalled output must hold
   always @(negedge clk) begin
      if (rst || !mon_en) begin
         prev_stall = 1'b0;
         prev_dat   = 8'h00;
      end else begin
         if (prev_stall) begin
            chk("hold_vld", 32'(out_vld), 32'd1);
            chk("hold_dat", 32'(out_dat), 32'(prev_dat));
         end
         if (out_vld && out_rdy) begin
            cap_q.push_back(out_dat);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_byte: got %0h want none", out_dat);
            end else begin
               chk("byte", 32'(out_dat), 32'(exp_q.pop_front()));
            end
         end
         prev_stall = out_vld && !out_rdy;
         prev_dat   = out_dat;
      end
   end

   task automatic wait_acc(input string name);
      int n = 0;
      @(negedge clk);
      while (!in_rdy && n < 400) begin
         n++;
         @(negedge clk);
      end
      if (!in_rdy) begin
         total++;
         bad++;
         $display("FAIL %s: got timeout want in_rdy", name);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] pl[$], input bit gaps);
      if (pl.size() == 0) begin
         in_vld = 1'b1; in_lst = 1'b1; in_emp = 1'b1; in_dat = 8'($urandom);
         wait_acc("acc_empty");
      end else begin
         for (int i = 0; i < pl.size(); i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
               in_vld = 1'b0;
               @(posedge clk);
               #1;
            end
            in_vld = 1'b1; in_dat = pl[i]; in_lst = (i == pl.size() - 1); in_emp = 1'b0;
            wait_acc("acc_byte");
         end
      end
      in_vld = 1'b0; in_lst = 1'b0; in_emp = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_left", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic send_ack(input bit nak);
      ack_vld = 1'b1; ack_nak = nak;
      @(posedge clk);
      #1;
      ack_vld = 1'b0; ack_nak = 1'b0;
   endtask

   task automatic finish_pkt();
`ifdef GDB_RSP_TX_RETRY_EN
      send_ack(1'b0);
`endif
      @(negedge clk);
      chk("busy_done", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_cap(input string name, input logic [7:0] lit[$]);
      chk({name, "_len"}, 32'(cap_q.size()), 32'(lit.size()));
      for (int i = 0; i < lit.size() && i < cap_q.size(); i++) begin
         chk(name, 32'(cap_q[i]), 32'(lit[i]));
      end
      cap_q.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] pl[$];
      logic [7:0] ok[$];
      logic [7:0] lit_ok[$];
      logic [7:0] lit[$];
      int         n;
      int         r;
      logic [7:0] b;

      rst = 1'b1; in_vld = 1'b0; in_dat = 8'h00; in_lst = 1'b0; in_emp = 1'b0;
      ack_vld = 1'b0; ack_nak = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_vld", 32'(out_vld), 32'd0);
      chk("rst_in_rdy", 32'(in_rdy), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err_ovf", 32'(err_ovf), 32'd0);
      chk("rst_err_retry", 32'(err_retry), 32'd0);
      rst = 1'b0;
      mon_en = 1'b1;
      @(posedge clk);
      #1;

      ok     = '{8'h4F, 8'h4B};
      lit_ok = '{8'h24, 8'h4F, 8'h4B, 8'h23, 8'h39, 8'h61};

      cap_q.delete();
      model_frame(ok); send(ok, 1'b0); drain(); finish_pkt();
      chk_cap("ok_bytes", lit_ok);

      pl.delete();
      model_frame(pl); send(pl, 1'b0); drain(); finish_pkt();
      lit = '{8'h24, 8'h23, 8'h30, 8'h30};
      chk_cap("empty_bytes", lit);

      pl = '{8'h23};
      model_frame(pl); send(pl, 1'b0); drain(); finish_pkt();
      lit = '{8'h24, 8'h7D, 8'h03, 8'h23, 8'h38, 8'h30};
      chk_cap("esc_bytes", lit);

      bp_en = 1'b1;
      for (int t = 0; t < 40; t++) begin
         pl.delete();
         n = $urandom_range(0, 12);
         for (int k = 0; k < n; k++) begin
            r = $urandom_range(0, 7);
            case (r)
               0: b = 8'h23;
               1: b = 8'h24;
               2: b = 8'h7D;
               3: b = 8'h2A;
               default: b = 8'($urandom);
            endcase
            pl.push_back(b);
         end
         model_frame(pl); send(pl, 1'b1); drain();
`ifdef GDB_RSP_TX_RETRY_EN
         if ($urandom_range(0, 2) == 0) begin
            model_frame(pl); send_ack(1'b1); drain();
         end
`endif
         finish_pkt();
      end

      cap_q.delete();
      model_frame(ok); send(ok, 1'b1); drain(); finish_pkt();
      chk_cap("ok_bp", lit_ok);
      bp_en = 1'b0;

`ifdef GDB_RSP_TX_RETRY_EN
      lit.delete();
      for (int k = 0; k < 3; k++) begin
         foreach (lit_ok[i]) lit.push_back(lit_ok[i]);
      end

      cap_q.delete();
      model_frame(ok); send(ok, 1'b0); drain();
      model_frame(ok); send_ack(1'b1); drain();
      model_frame(ok); send_ack(1'b1); drain();
      send_ack(1'b0);
      @(negedge clk);
      chk("nak_busy", 32'(busy), 32'd0);
      chk("nak_err_retry", 32'(err_retry), 32'd0);
      chk_cap("nak_x3", lit);
      @(posedge clk);
      #1;

      cap_q.delete();
      model_frame(ok); model_frame(ok); model_frame(ok);
      send(ok, 1'b0); drain();
      n = 0;
      while (busy && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("to_busy", 32'(busy), 32'd0);
      chk("to_err_retry", 32'(err_retry), 32'd1);
      chk("to_err_ovf", 32'(err_ovf), 32'd0);
      repeat (30) @(posedge clk);
      #1;
      chk_cap("to_x3", lit);

      pl.delete();
      for (int k = 0; k < 20; k++) pl.push_back(8'h41 + 8'(k));
      model_frame(pl); send(pl, 1'b0); drain();
      send_ack(1'b1);
      @(negedge clk);
      chk("ovf_busy", 32'(busy), 32'd0);
      chk("ovf_err_ovf", 32'(err_ovf), 32'd1);
      repeat (20) @(posedge clk);
      #1;
`endif

      mon_en = 1'b0;
      @(posedge clk);
      #1;
      in_vld = 1'b1; in_dat = 8'h41; in_lst = 1'b0; in_emp = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      chk("pre_rst_vld", 32'(out_vld), 32'd1);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_mid_vld", 32'(out_vld), 32'd0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_in_rdy", 32'(in_rdy), 32'd0);
      in_vld = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      cap_q.delete();
      mon_en = 1'b1;
      chk("post_rst_err_ovf", 32'(err_ovf), 32'd0);
      chk("post_rst_err_retry", 32'(err_retry), 32'd0);
      model_frame(ok); send(ok, 1'b0); drain(); finish_pkt();
      chk_cap("post_rst", lit_ok);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
